vfu_result_wb_buffer: RTL and testbench



---
 rtl/vfu_result_wb_buffer_pkg.sv | 21 ++
 rtl/vfu_result_wb_buffer_fifo.sv | 69 ++++++
 rtl/vfu_result_wb_buffer.sv | 145 ++++++++++++++
 tb/tb_vfu_result_wb_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfu_result_wb_buffer_pkg.sv
// Shared types for the per-lane result writeback buffer: element, strobe and id
// widths, plus the writeback source encoding.
package vfu_result_wb_buffer_pkg;

  localparam int unsigned NrVInsn = 8;
  localparam int unsigned ELEN    = 64;

  typedef logic [$clog2(NrVInsn)-1:0] vid_t;
  typedef logic [ELEN-1:0]            elen_t;
  typedef logic [ELEN/8-1:0]          strb_t;

  typedef enum logic {
    WbSrcAlu  = 1'b0,
    WbSrcMfpu = 1'b1
  } wb_src_e;

  function automatic wb_src_e other_src(input wb_src_e src);
    return (src == WbSrcAlu) ? WbSrcMfpu : WbSrcAlu;
  endfunction

endpackage

// File: rtl/vfu_result_wb_buffer_fifo.sv
// Synchronous-reset FIFO holding FU results. Full is taken from the pre-pop
// count, so a full FIFO refuses a push even while it is being popped.
module wb_result_fifo #(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  entry_t          mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] cnt;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? {PtrW{1'b0}} : ptr + PtrW'(1);
  endfunction

  assign full_o  = (cnt == DepthCnt);
  assign empty_o = empty;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty;
  assign data_o  = mem[rd_ptr];

  // Pointer, occupancy and registered empty flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= {PtrW{1'b0}};
      rd_ptr <= {PtrW{1'b0}};
      cnt    <= {CntW{1'b0}};
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10: begin
          cnt   <= cnt + CntW'(1);
          empty <= 1'b0;
        end
        2'b01: begin
          cnt   <= cnt - CntW'(1);
          empty <= (cnt == CntW'(1));
        end
        default: ;
      endcase
    end
  end

  // Storage; contents are only visible through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/vfu_result_wb_buffer.sv
// Per-lane writeback buffer: ALU and MFPU results are queued separately and
// arbitrated round-robin onto one VRF write port, with a lock that keeps a
// raised request stable until the VRF grants it.
module vfu_result_wb_buffer
  import vfu_result_wb_buffer_pkg::*;
#(
  parameter int          NrLanes = 0,
  parameter type         vaddr_t = logic,
  parameter int unsigned Depth   = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    alu_result_req_i,
  input  vid_t    alu_result_id_i,
  input  vaddr_t  alu_result_addr_i,
  input  elen_t   alu_result_wdata_i,
  input  strb_t   alu_result_be_i,
  output logic    alu_result_gnt_o,
  input  logic    mfpu_result_req_i,
  input  vid_t    mfpu_result_id_i,
  input  vaddr_t  mfpu_result_addr_i,
  input  elen_t   mfpu_result_wdata_i,
  input  strb_t   mfpu_result_be_i,
  output logic    mfpu_result_gnt_o,
  output logic    wb_req_o,
  output vid_t    wb_id_o,
  output vaddr_t  wb_addr_o,
  output elen_t   wb_wdata_o,
  output strb_t   wb_be_o,
  output wb_src_e wb_src_o,
  input  logic    wb_gnt_i,
  output logic    alu_wb_empty_o,
  output logic    mfpu_wb_empty_o
);

  if (Depth < 1 || (Depth & (Depth - 1)) != 0 || NrLanes < 0) begin : g_bad_param
    $error("vfu_result_wb_buffer: Depth must be a power of two >= 1");
  end

  typedef struct packed {
    vid_t   id;
    vaddr_t addr;
    elen_t  wdata;
    strb_t  be;
  } entry_t;

  entry_t  alu_in, mfpu_in, alu_head, mfpu_head, head;
  logic    alu_full, alu_empty, mfpu_full, mfpu_empty;
  logic    alu_pop, mfpu_pop;
  wb_src_e sel, sel_r, prio_r;
  logic    lock_r, sel_valid, fire;

  assign alu_in  = '{id: alu_result_id_i, addr: alu_result_addr_i,
                     wdata: alu_result_wdata_i, be: alu_result_be_i};
  assign mfpu_in = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i,
                     wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};

  assign alu_result_gnt_o  = alu_result_req_i & ~alu_full;
  assign mfpu_result_gnt_o = mfpu_result_req_i & ~mfpu_full;
  assign alu_wb_empty_o    = alu_empty;
  assign mfpu_wb_empty_o   = mfpu_empty;

  wb_result_fifo #(.Depth(Depth), .entry_t(entry_t)) i_alu_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (alu_result_req_i),
    .data_i  (alu_in),
    .pop_i   (alu_pop),
    .data_o  (alu_head),
    .full_o  (alu_full),
    .empty_o (alu_empty)
  );

  wb_result_fifo #(.Depth(Depth), .entry_t(entry_t)) i_mfpu_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mfpu_result_req_i),
    .data_i  (mfpu_in),
    .pop_i   (mfpu_pop),
    .data_o  (mfpu_head),
    .full_o  (mfpu_full),
    .empty_o (mfpu_empty)
  );

  // Source selection: a locked request keeps its source until granted.
  always_comb begin
    sel = sel_r;
    if (lock_r) begin
      sel = sel_r;
    end else if (!alu_empty && mfpu_empty) begin
      sel = WbSrcAlu;
    end else if (alu_empty && !mfpu_empty) begin
      sel = WbSrcMfpu;
    end else if (!alu_empty && !mfpu_empty) begin
      sel = prio_r;
    end else begin
      sel = sel_r;
    end
  end

  assign sel_valid = (sel == WbSrcAlu) ? ~alu_empty : ~mfpu_empty;
  assign fire      = sel_valid & wb_gnt_i;
  assign alu_pop   = fire & (sel == WbSrcAlu);
  assign mfpu_pop  = fire & (sel == WbSrcMfpu);
  assign head      = (sel == WbSrcAlu) ? alu_head : mfpu_head;

  // Write port drive; fields read as zero whenever no request is raised.
  always_comb begin
    wb_req_o   = sel_valid;
    wb_id_o    = '0;
    wb_addr_o  = '0;
    wb_wdata_o = '0;
    wb_be_o    = '0;
    wb_src_o   = WbSrcAlu;
    if (sel_valid) begin
      wb_id_o    = head.id;
      wb_addr_o  = head.addr;
      wb_wdata_o = head.wdata;
      wb_be_o    = head.be;
      wb_src_o   = sel;
    end else begin
      wb_src_o   = WbSrcAlu;
    end
  end

  // Arbiter state: selection, lock on an ungranted request, round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_r  <= WbSrcAlu;
      prio_r <= WbSrcAlu;
      lock_r <= 1'b0;
    end else begin
      sel_r <= sel;
      if (fire) begin
        lock_r <= 1'b0;
        prio_r <= other_src(sel);
      end else if (sel_valid) begin
        lock_r <= 1'b1;
      end else begin
        lock_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vfu_result_wb_buffer.sv
// Scoreboard bench for vfu_result_wb_buffer: directed pushes queue the expected
// writes in hand-derived order; a negedge monitor checks every granted write.
module tb_vfu_result_wb_buffer;
  import vfu_result_wb_buffer_pkg::*;

  typedef logic [15:0] addr_t;
  typedef struct packed {
    vid_t  id;
    addr_t addr;
    elen_t wdata;
    strb_t be;
  } ent_t;
  typedef struct packed {
    logic src;
    ent_t e;
  } exp_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    alu_req, mfpu_req, wb_gnt;
  ent_t    alu_e, mfpu_e;
  logic    alu_gnt, mfpu_gnt, wb_req, alu_empty, mfpu_empty;
  vid_t    wb_id;
  addr_t   wb_addr;
  elen_t   wb_wdata;
  strb_t   wb_be;
  wb_src_e wb_src;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  vfu_result_wb_buffer #(.NrLanes(4), .vaddr_t(addr_t), .Depth(2)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .alu_result_req_i    (alu_req),
    .alu_result_id_i     (alu_e.id),
    .alu_result_addr_i   (alu_e.addr),
    .alu_result_wdata_i  (alu_e.wdata),
    .alu_result_be_i     (alu_e.be),
    .alu_result_gnt_o    (alu_gnt),
    .mfpu_result_req_i   (mfpu_req),
    .mfpu_result_id_i    (mfpu_e.id),
    .mfpu_result_addr_i  (mfpu_e.addr),
    .mfpu_result_wdata_i (mfpu_e.wdata),
    .mfpu_result_be_i    (mfpu_e.be),
    .mfpu_result_gnt_o   (mfpu_gnt),
    .wb_req_o            (wb_req),
    .wb_id_o             (wb_id),
    .wb_addr_o           (wb_addr),
    .wb_wdata_o          (wb_wdata),
    .wb_be_o             (wb_be),
    .wb_src_o            (wb_src),
    .wb_gnt_i            (wb_gnt),
    .alu_wb_empty_o      (alu_empty),
    .mfpu_wb_empty_o     (mfpu_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic ent_t mk(input int id, input int addr, input logic [63:0] d, input int be);
    ent_t e;
    e.id = vid_t'(id); e.addr = addr_t'(addr); e.wdata = d; e.be = strb_t'(be);
    return e;
  endfunction

  task automatic step(input logic ar, input ent_t ae, input logic mr, input ent_t me, input logic g);
    alu_req = ar; alu_e = ae; mfpu_req = mr; mfpu_e = me; wb_gnt = g;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic src, input ent_t e);
    exp_q.push_back({src, e});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && alu_empty && mfpu_empty) break;
      step(1'b0, '0, 1'b0, '0, 1'b1);
      tick();
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every granted write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (wb_req && wb_gnt) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (t=%0t)",
                   wb_addr, wb_wdata, $time);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("wb_src",   64'(wb_src),   64'(x.src));
          chk("wb_id",    64'(wb_id),    64'(x.e.id));
          chk("wb_addr",  64'(wb_addr),  64'(x.e.addr));
          chk("wb_wdata", wb_wdata,      x.e.wdata);
          chk("wb_be",    64'(wb_be),    64'(x.e.be));
        end
      end else if (!wb_req) begin
        chk("idle_zero", wb_wdata | 64'(wb_addr) | 64'(wb_be) | 64'(wb_id), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t s, a0, a1, a2, m0, m1, p, x, b;
    s  = mk(1, 16'h0010, 64'h0000_0000_DEAD_BEEF, 8'hFF);
    a0 = mk(2, 16'h0100, 64'h1111_0000_0000_0001, 8'h0F);
    a1 = mk(3, 16'h0104, 64'h1111_0000_0000_0002, 8'hF0);
    a2 = mk(4, 16'h0108, 64'h1111_0000_0000_0003, 8'h3C);
    m0 = mk(5, 16'h0200, 64'h2222_0000_0000_0001, 8'h01);
    m1 = mk(6, 16'h0204, 64'h2222_0000_0000_0002, 8'h80);
    p  = mk(7, 16'h0300, 64'h3333_0000_0000_0001, 8'hAA);
    x  = mk(0, 16'h0310, 64'h4444_5555_6666_7777, 8'h55);
    b  = mk(1, 16'h0320, 64'h8888_9999_AAAA_BBBB, 8'hC3);

    // Reset state
    rst = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    tick();
    chk("rst_wb_req", 64'(wb_req), 64'd0);
    chk("rst_alu_empty", 64'(alu_empty), 64'd1);
    chk("rst_mfpu_empty", 64'(mfpu_empty), 64'd1);
    chk("rst_alu_gnt", 64'(alu_gnt), 64'd0);
    chk("rst_src", 64'(wb_src), 64'd0);
    rst = 1'b0;

    // Single ALU push with grant held high
    step(1'b1, s, 1'b0, '0, 1'b1);
    chk("t1_gnt", 64'(alu_gnt), 64'd1);
    chk("t1_no_fallthrough", 64'(wb_req), 64'd0);
    expect_wr(1'b0, s);
    tick();
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t1_req_n1", 64'(wb_req), 64'd1);
    chk("t1_alu_empty_n1", 64'(alu_empty), 64'd0);
    tick();
    step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t1_alu_empty_n2", 64'(alu_empty), 64'd1);
    chk("t1_req_n2", 64'(wb_req), 64'd0);
    tick();

    // Three ALU pushes into a depth-2 FIFO with no grant
    step(1'b1, a0, 1'b0, '0, 1'b0);
    chk("t2_gnt0", 64'(alu_gnt), 64'd1);
    expect_wr(1'b0, a0);
    tick();
    step(1'b1, a1, 1'b0, '0, 1'b0);
    chk("t2_gnt1", 64'(alu_gnt), 64'd1);
    expect_wr(1'b0, a1);
    tick();
    step(1'b1, a2, 1'b0, '0, 1'b0);
    chk("t2_full_refuse", 64'(alu_gnt), 64'd0);
    tick();
    step(1'b1, a2, 1'b0, '0, 1'b1);
    chk("t2_full_pop_refuse", 64'(alu_gnt), 64'd0);
    chk("t2_head_addr", 64'(wb_addr), 64'(a0.addr));
    tick();
    step(1'b1, a2, 1'b0, '0, 1'b1);
    chk("t2_third_accept", 64'(alu_gnt), 64'd1);
    expect_wr(1'b0, a2);
    tick();
    drain(10);

    // Both FIFOs full: grants must alternate ALU, MFPU, ALU, MFPU
    do_reset();
    step(1'b1, a0, 1'b1, m0, 1'b0);
    chk("t3_alu_gnt", 64'(alu_gnt), 64'd1);
    chk("t3_mfpu_gnt", 64'(mfpu_gnt), 64'd1);
    tick();
    step(1'b1, a1, 1'b1, m1, 1'b0);
    chk("t3_first_src", 64'(wb_src), 64'd0);
    tick();
    expect_wr(1'b0, a0);
    expect_wr(1'b1, m0);
    expect_wr(1'b0, a1);
    expect_wr(1'b1, m1);
    drain(10);

    // Locked ALU request stays stable while MFPU pushes and holds priority
    step(1'b1, p, 1'b0, '0, 1'b1);
    expect_wr(1'b0, p);
    tick();
    step(1'b0, '0, 1'b0, '0, 1'b1);
    tick();
    step(1'b1, x, 1'b0, '0, 1'b0);
    expect_wr(1'b0, x);
    tick();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, (i < 2), (i == 0) ? m0 : m1, 1'b0);
      chk("t4_req", 64'(wb_req), 64'd1);
      chk("t4_src", 64'(wb_src), 64'd0);
      chk("t4_addr", 64'(wb_addr), 64'(x.addr));
      chk("t4_wdata", wb_wdata, x.wdata);
      if (i < 2) begin
        chk("t4_mfpu_gnt", 64'(mfpu_gnt), 64'd1);
        expect_wr(1'b1, (i == 0) ? m0 : m1);
      end
      tick();
    end
    drain(10);

    // Reset with entries buffered discards them
    step(1'b1, a0, 1'b1, m0, 1'b0);
    tick();
    step(1'b1, a1, 1'b0, '0, 1'b0);
    tick();
    rst = 1'b1;
    step(1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    chk("t5_req_after_rst", 64'(wb_req), 64'd0);
    chk("t5_alu_empty", 64'(alu_empty), 64'd1);
    chk("t5_mfpu_empty", 64'(mfpu_empty), 64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, '0, 1'b1);
      chk("t5_no_stale", 64'(wb_req), 64'd0);
      tick();
    end

    // Push and pop at count 1
    step(1'b1, a0, 1'b0, '0, 1'b0);
    expect_wr(1'b0, a0);
    tick();
    step(1'b1, b, 1'b0, '0, 1'b1);
    chk("t6_gnt", 64'(alu_gnt), 64'd1);
    expect_wr(1'b0, b);
    tick();
    step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("t6_req", 64'(wb_req), 64'd1);
    chk("t6_not_empty", 64'(alu_empty), 64'd0);
    chk("t6_head_addr", 64'(wb_addr), 64'(b.addr));
    tick();
    drain(10);
    chk("t6_empty_end", 64'(alu_empty), 64'd1);

    chk("queue_end", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
